// File: rtl/wb_burst_ram.sv
// wb_burst_ram: Wishbone B3 slave RAM with registered-feedback burst support.
// Handles classic, constant and incrementing (linear / wrap-4/8/16) bursts
// with byte selects. Accesses outside the window terminate with a one-cycle err.
//
// Handshake: a beat is requested while wb_cyc_i & wb_stb_i (req) is high.
// The master holds the beat's address/data/cti until it sees wb_ack_o or
// wb_err_o, which are registered and never high together. During an ack cycle
// the slave has already fetched the predicted next beat, so a burst whose
// cti is 001/010 and whose address matches the beat being acked runs at one
// beat per cycle.
module wb_burst_ram #(
    parameter int aw       = 32,
    parameter int dw       = 32,
    parameter int DEPTH    = 256,
    parameter int MEM_BASE = 0
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic [0:0]    dbg_state_o
);

    localparam int WW = aw - 2;
    localparam int IW = $clog2(DEPTH);
    localparam logic [WW-1:0] BASE_W = WW'(MEM_BASE / 4);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    localparam logic [2:0] CTI_CONST = 3'b001;
    localparam logic [2:0] CTI_INCR  = 3'b010;

    logic [dw-1:0] mem_q [DEPTH];

    logic [0:0]    state_q, state_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [dw-1:0] dat_q, dat_d;
    logic [aw-1:0] cur_q, cur_d;

    logic          req;
    logic [WW-1:0] adr_w, adr_off;
    logic          adr_in;
    logic [WW-1:0] nxt_w, nxt_off;
    logic [aw-1:0] nxt_adr;
    logic          nxt_in;
    logic          burst_go;
    logic          wr_en;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [dw-1:0] rd_word, fwd_word;

    assign req = wb_cyc_i & wb_stb_i;

    // Word offset of the presented address from the base of the window.
    assign adr_w   = wb_adr_i[aw-1:2];
    assign adr_off = adr_w - BASE_W;
    assign adr_in  = (adr_w >= BASE_W) && ((adr_off >> IW) == '0);

    // Predict the word of the following beat from the beat being acked.
    always_comb begin
        nxt_w = cur_q[aw-1:2];
        if (wb_cti_i == CTI_INCR) begin
            case (wb_bte_i)
                2'b00:   nxt_w      = cur_q[aw-1:2] + WW'(1);
                2'b01:   nxt_w[1:0] = cur_q[3:2] + 2'd1;
                2'b10:   nxt_w[2:0] = cur_q[4:2] + 3'd1;
                default: nxt_w[3:0] = cur_q[5:2] + 4'd1;
            endcase
        end
    end

    assign nxt_adr = {nxt_w, cur_q[1:0]};
    assign nxt_off = nxt_w - BASE_W;
    assign nxt_in  = (nxt_w >= BASE_W) && ((nxt_off >> IW) == '0);

    // Burst continues only when the master confirms the beat being acked.
    assign burst_go = req && (wb_cti_i == CTI_CONST || wb_cti_i == CTI_INCR) &&
                      (wb_adr_i == cur_q);

    // Writes complete on the edge that closes an ack cycle.
    assign wr_en  = (state_q == S_ACK) && req && wb_we_i && adr_in;
    assign wr_idx = adr_off[IW-1:0];
    assign rd_idx = (state_q == S_ACK) ? nxt_off[IW-1:0] : adr_off[IW-1:0];
    assign rd_word = mem_q[rd_idx];

    // Forward bytes written this cycle into a read of the same word.
    always_comb begin
        fwd_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (wr_en && (wr_idx == rd_idx) && wb_sel_i[b]) begin
                fwd_word[8*b +: 8] = wb_dat_i[8*b +: 8];
            end
        end
    end

    // Next-state and registered response for the current beat.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = '0;
        cur_d   = cur_q;
        case (state_q)
            S_IDLE: begin
                // The cycle carrying err closes that beat; do not re-accept it.
                if (req && !err_q) begin
                    if (adr_in) begin
                        ack_d   = 1'b1;
                        dat_d   = fwd_word;
                        cur_d   = wb_adr_i;
                        state_d = S_ACK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (burst_go) begin
                    if (nxt_in) begin
                        ack_d   = 1'b1;
                        dat_d   = fwd_word;
                        cur_d   = nxt_adr;
                        state_d = S_ACK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            cur_q   <= cur_d;
        end
    end

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign wb_rty_o    = 1'b0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_burst_ram.sv
// tb_wb_burst_ram: directed and randomized bursts against a transaction-level
// memory model; expected beat responses are queued before each burst.
module tb_wb_burst_ram;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int DEPTH    = 256;
    localparam int MEM_BASE = 0;
    localparam int EW       = 34;   // [33] data known, [32] err, [31:0] data

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [DW-1:0] dat_r;
    logic          ack;
    logic          err;
    logic          rty;
    logic [0:0]    dbg;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];
    logic [31:0]   adr_q[$];
    logic [31:0]   ref_mem [DEPTH];
    bit            ref_vld [DEPTH];
    logic [31:0]   wdat [256];
    logic [3:0]    wsel [256];
    logic [31:0]   last_dat;

    wb_burst_ram #(
        .aw(AW), .dw(DW), .DEPTH(DEPTH), .MEM_BASE(MEM_BASE)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb_adr_i(adr),
        .wb_dat_i(dat_w),
        .wb_sel_i(sel),
        .wb_we_i(we),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_cti_i(cti),
        .wb_bte_i(bte),
        .wb_dat_o(dat_r),
        .wb_ack_o(ack),
        .wb_err_o(err),
        .wb_rty_o(rty),
        .dbg_state_o(dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit in_rng(input longint unsigned a);
        return (a >= longint'(MEM_BASE)) && (a < longint'(MEM_BASE) + 4 * DEPTH);
    endfunction

    function automatic longint unsigned nxt_word(input longint unsigned w, input int kind,
                                                 input int bte_v);
        longint unsigned n;
        if (kind == 1) return w;
        if (bte_v == 0) return (w + 1) % (64'd1 << 30);
        n = 64'd2 << bte_v;
        return (w / n) * n + (w + 1) % n;
    endfunction

    // Build the expected response of every beat and update the model memory.
    task automatic plan(input logic [31:0] start, input int kind, input int bte_v,
                        input int n, input bit we_v);
        longint unsigned w, a;
        int idx;
        exp_q.delete();
        adr_q.delete();
        w = {32'b0, start} >> 2;
        for (int k = 0; k < n; k++) begin
            a = w * 4;
            adr_q.push_back(32'(a) | {30'b0, start[1:0]});
            if (!in_rng(a)) begin
                exp_q.push_back({1'b0, 1'b1, 32'h0});
                break;
            end
            idx = int'((a - longint'(MEM_BASE)) / 4);
            exp_q.push_back({ref_vld[idx], 1'b0, ref_mem[idx]});
            if (we_v) begin
                for (int b = 0; b < 4; b++) begin
                    if (wsel[k][b]) ref_mem[idx][8*b +: 8] = wdat[k][8*b +: 8];
                end
                if (wsel[k] == 4'hf) ref_vld[idx] = 1'b1;
            end
            w = nxt_word(w, kind, bte_v);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input int kind, input int bte_v, input int n, input bit we_v,
                         input int gap);
        logic [EW-1:0] e;
        logic [1:0]    want;
        int            waits;
        int            beats;
        bit            abort;
        beats    = exp_q.size();
        abort    = 1'b0;
        last_dat = '0;
        for (int k = 0; k < beats && !abort; k++) begin
            e     = exp_q.pop_front();
            cyc   = 1'b1;
            stb   = 1'b1;
            we    = we_v;
            adr   = adr_q.pop_front();
            dat_w = wdat[k];
            sel   = wsel[k];
            bte   = 2'(bte_v);
            if (kind == 0)      cti = 3'b000;
            else if (k == n-1)  cti = 3'b111;
            else if (kind == 1) cti = 3'b001;
            else                cti = 3'b010;
            waits = 0;
            forever begin
                @(negedge clk);
                if (ack || err || waits == 4) break;
                waits++;
                @(posedge clk);
                #1;
            end
            want = e[32] ? 2'b10 : 2'b01;
            check("beat_resp", {err, ack}, want);
            if (k == 0) check("first_lat", waits, 1);
            else        check("burst_lat", waits, 0);
            if (ack && !e[32]) begin
                last_dat = dat_r;
                if (e[33]) check("beat_data", dat_r, e[31:0]);
            end
            if ({err, ack} != want) abort = 1'b1;
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        adr_q.delete();
        if (gap > 0) begin
            cyc = 1'b0;
            stb = 1'b0;
            we  = 1'b0;
            cti = 3'b000;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("idle_resp", {err, ack}, 2'b00);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic burst(input logic [31:0] start, input int kind, input int bte_v,
                         input int n, input bit we_v, input int gap);
        plan(start, kind, bte_v, n, we_v);
        drive(kind, bte_v, n, we_v, gap);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d3 [4];
        logic [31:0] t3_exp [4];

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_w = '0; sel = '0; cti = '0; bte = '0;
        for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", ack, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_dat", dat_r, 32'h0);
        check("rst_state", dbg, 1'b0);
        @(posedge clk);
        #1;

        // Fill the whole memory with one long linear burst.
        for (int k = 0; k < 256; k++) begin
            wdat[k] = $urandom;
            wsel[k] = 4'hf;
        end
        burst(32'(MEM_BASE), 2, 0, DEPTH, 1'b1, 1);

        // Classic write then read.
        wdat[0] = 32'hDEADBEEF; wsel[0] = 4'hf;
        burst(32'h10, 0, 0, 1, 1'b1, 1);
        burst(32'h10, 0, 0, 1, 1'b0, 1);
        check("t1_read", last_dat, 32'hDEADBEEF);

        // Byte mask.
        wdat[0] = 32'hAABBCCDD; wsel[0] = 4'hf;
        burst(32'h20, 0, 0, 1, 1'b1, 1);
        wdat[0] = 32'h11223344; wsel[0] = 4'b0101;
        burst(32'h20, 0, 0, 1, 1'b1, 0);
        burst(32'h20, 0, 0, 1, 1'b0, 1);
        check("t2_mask", last_dat, 32'hAA22CC44);

        // Wrap-4 write burst starting mid-block.
        for (int k = 0; k < 4; k++) begin
            d3[k]   = 32'hD000_0000 + 32'(k) * 32'h0101_0101;
            wdat[k] = d3[k];
            wsel[k] = 4'hf;
        end
        t3_exp[0] = d3[2]; t3_exp[1] = d3[3]; t3_exp[2] = d3[0]; t3_exp[3] = d3[1];
        burst(32'h38, 2, 1, 4, 1'b1, 1);
        for (int k = 0; k < 4; k++) begin
            burst(32'h30 + 32'(k) * 4, 0, 0, 1, 1'b0, 1);
            check("t3_wrap", last_dat, t3_exp[k]);
        end

        // Linear read running off the end, then a far out-of-range read.
        burst(32'h3F0, 2, 0, 5, 1'b0, 2);
        burst(32'h1000, 0, 0, 1, 1'b0, 2);

        // Constant write burst.
        for (int k = 0; k < 3; k++) begin
            wdat[k] = 32'(k + 1);
            wsel[k] = 4'hf;
        end
        burst(32'h40, 1, 0, 3, 1'b1, 1);
        burst(32'h40, 0, 0, 1, 1'b0, 1);
        check("t5_const", last_dat, 32'h3);

        // Reset during the second beat of a linear read burst.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h80; cti = 3'b010; bte = 2'b00;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t6_beat0_ack", ack, 1'b1);
        @(posedge clk);
        #1;
        adr = 32'h84;
        @(negedge clk);
        check("t6_beat1_ack", ack, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        @(negedge clk);
        check("t6_ack", ack, 1'b0);
        check("t6_err", err, 1'b0);
        check("t6_dat", dat_r, 32'h0);
        check("t6_state", dbg, 1'b0);
        @(posedge clk);
        #1;
        burst(32'h84, 0, 0, 1, 1'b0, 1);
        burst(32'h10, 0, 0, 1, 1'b0, 1);
        check("t6_keep", last_dat, 32'hDEADBEEF);

        // Randomized bursts.
        for (int t = 0; t < 150; t++) begin
            int kind;
            int n;
            int bte_v;
            int r;
            logic [31:0] start;
            kind  = $urandom_range(0, 2);
            n     = (kind == 0) ? 1 : $urandom_range(2, 8);
            bte_v = $urandom_range(0, 3);
            r     = $urandom_range(0, 99);
            if (r < 80)      start = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (r < 95) start = 32'($urandom_range(DEPTH - 4, DEPTH + 3)) * 4;
            else             start = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            start = start + 32'(MEM_BASE) + 32'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) begin
                wdat[k] = $urandom;
                wsel[k] = 4'($urandom_range(0, 15));
            end
            burst(start, kind, bte_v, n, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("rty_tied", rty, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
